// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: latches a load/store, drives req/ack, stalls the pipeline, aborts on timeout.
// Latency >= 2 stall cycles (detect + one BUSY); stall_o backpressures PC and all pipeline registers until DONE.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              abort;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              access;
    logic              timeout_hit;

    assign access      = MemRead_i | MemWrite_i;
    assign timeout_hit = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            abort   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        we_q    <= MemWrite_i;
                        cnt     <= '0;
                        abort   <= 1'b0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // An ack in the final allowed cycle takes priority over the abort.
                    if (mem_ack_i) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        abort   <= 1'b1;
                        state   <= S_DONE;
                    end
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    cnt   <= '0;
                    abort <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = (state == S_BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    // DONE never stalls: the pipeline advances at the end of that cycle.
    assign stall_o     = ((state == S_IDLE) && access) || (state == S_BUSY);
    assign err_o       = (state == S_DONE) && abort;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: unit 0 uses the default timeout, unit 1 uses TIMEOUT=4.
module tb_mem_access_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rd, wr, ack, req, we, stall, err;
    logic [1:0][AW-1:0] addr, maddr;
    logic [1:0][DW-1:0] wd, mwd, mrd, rdat;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
        .addr_i(addr[0]), .wdata_i(wd[0]), .mem_req_o(req[0]), .mem_we_o(we[0]),
        .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]), .mem_ack_i(ack[0]),
        .mem_rdata_i(mrd[0]), .rdata_o(rdat[0]), .stall_o(stall[0]), .err_o(err[0])
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut_to (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
        .addr_i(addr[1]), .wdata_i(wd[1]), .mem_req_o(req[1]), .mem_we_o(we[1]),
        .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]), .mem_ack_i(ack[1]),
        .mem_rdata_i(mrd[1]), .rdata_o(rdat[1]), .stall_o(stall[1]), .err_o(err[1])
    );

    typedef struct {
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          e;
        int            st;
        int            rq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
    endtask

    // Monitor: accumulates stall/req cycles per access and scores each DONE cycle.
    int st_n[2];
    int rq_n[2];
    logic [1:0] prev_req, after_done, unstab, w0;
    logic [1:0][AW-1:0] a0;
    logic [1:0][DW-1:0] wd0;

    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                st_n[d] = 0; rq_n[d] = 0;
                prev_req[d] = 1'b0; after_done[d] = 1'b0; unstab[d] = 1'b0;
            end else begin
                if (after_done[d]) chk("err_one_cycle", err[d], 0);
                after_done[d] = 1'b0;
                if (stall[d]) st_n[d]++;
                if (req[d]) begin
                    if (rq_n[d] == 0) begin
                        a0[d] = maddr[d]; w0[d] = we[d]; wd0[d] = mwd[d];
                    end else if (maddr[d] != a0[d] || we[d] != w0[d] || mwd[d] != wd0[d]) begin
                        unstab[d] = 1'b1;
                    end
                    rq_n[d]++;
                end else if (prev_req[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk("addr", a0[d], e.a);
                        chk("we", w0[d], e.w);
                        chk("wdata", wd0[d], e.wd);
                        chk("busy_stable", unstab[d], 0);
                        chk("rdata", rdat[d], e.rd);
                        chk("err", err[d], e.e);
                        chk("done_stall", stall[d], 0);
                        chk("stall_cycles", st_n[d], e.st);
                        chk("req_cycles", rq_n[d], e.rq);
                    end
                    st_n[d] = 0; rq_n[d] = 0; unstab[d] = 1'b0; after_done[d] = 1'b1;
                end
                prev_req[d] = req[d];
            end
        end
    end

    // One access; dly = BUSY cycles before the ack cycle, or -1 for no ack (runs tocyc BUSY cycles).
    task automatic op(input int d, input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wdv, input int dly, input int tocyc, input logic [DW-1:0] ad,
                      input logic [DW-1:0] erd, input logic ee, input int est, input int erq);
        exp_t e;
        @(posedge clk); #1;
        rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdv;
        e = '{a, w, wdv, erd, ee, est, erq};
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(posedge clk); #1;
        if (dly >= 0) begin
            repeat (dly) begin @(posedge clk); #1; end
            ack[d] = 1'b1; mrd[d] = ad;
            @(posedge clk); #1;
            ack[d] = 1'b0;
        end else begin
            repeat (tocyc) begin @(posedge clk); #1; end
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        rd = '0; wr = '0; ack = '0; addr = '0; wd = '0; mrd = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", maddr[0], 0);
        chk("rst_wdata", mwd[0], 0);
        chk("rst_rdata", rdat[0], 0);
        rst_n = 1'b1;

        // d, rd, wr, addr, wdata, dly, tocyc, ack data, exp rdata, exp err, exp stall, exp req
        op(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 1);
        op(0, 0, 1, 32'h20, 32'h5, 4, 0, 32'h12345678, 32'hDEADBEEF, 0, 6, 5);
        op(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 2, 1);
        op(0, 0, 1, 32'h44, 32'hA5A5A5A5, 0, 0, 32'h0, 32'hCAFEF00D, 0, 2, 1);
        op(0, 1, 1, 32'h30, 32'h77, 0, 0, 32'hBAD, 32'hCAFEF00D, 0, 2, 1);

        @(posedge clk); #1;
        ack[0] = 1'b1; mrd[0] = 32'h11111111;
        @(posedge clk); #1;
        ack[0] = 1'b0;
        chk("spurious_req", req[0], 0);
        chk("spurious_stall", stall[0], 0);
        chk("spurious_rdata", rdat[0], 32'hCAFEF00D);
        op(0, 1, 0, 32'h50, 32'h0, 1, 0, 32'h0BADCAFE, 32'h0BADCAFE, 0, 3, 2);

        // Asynchronous reset in the middle of a BUSY access.
        @(posedge clk); #1;
        rd[0] = 1'b1; addr[0] = 32'h70;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_req", req[0], 1);
        #1;
        rd[0] = 1'b0; rst_n = 1'b0;
        #1;
        chk("async_rst_req", req[0], 0);
        chk("async_rst_stall", stall[0], 0);
        chk("async_rst_err", err[0], 0);
        chk("async_rst_rdata", rdat[0], 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ack[0] = 1'b1; mrd[0] = 32'h99;
        @(posedge clk); #1;
        ack[0] = 1'b0;
        chk("post_rst_ack_req", req[0], 0);
        chk("post_rst_ack_rdata", rdat[0], 0);

        op(1, 1, 0, 32'h64, 32'h0, 0, 0, 32'hFFFF0000, 32'hFFFF0000, 0, 2, 1);
        op(1, 1, 0, 32'h60, 32'h0, -1, 4, 32'h0, 32'h0, 1, 5, 4);
        op(1, 1, 0, 32'h68, 32'h0, 3, 0, 32'h13579BDF, 32'h13579BDF, 0, 5, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the pipeline's data-memory access when the memory has variable, multi-cycle latency.
- Sits at the MEM stage and consumes the decoded MemRead/MemWrite strobes that travel down from the instruction decoder.
- Drives a req/ack handshake to the data memory and asserts a global stall to all pipeline registers and the PC until the access completes.
- Returns load data to the MEM/WB register and flags accesses that time out.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum BUSY cycles without ack before abort (>=1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- MemRead_i  in  1  MEM-stage load strobe
- MemWrite_i  in  1  MEM-stage store strobe
- addr_i  in  ADDR_W  ALU result (effective address)
- wdata_i  in  DATA_W  store data (rt value)
- mem_req_o  out  1  request to data memory
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched store data
- mem_ack_i  in  1  memory completion, single-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- rdata_o  out  DATA_W  load data to MEM/WB register
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- err_o  out  1  timeout abort, one-cycle pulse

Behaviour:
- Reset (rst_i=0, any time, including mid-access): state=IDLE; mem_req_o, mem_we_o, err_o = 0; mem_addr_o, mem_wdata_o, rdata_o, timeout counter = 0. Any pending access is dropped; no ack is awaited after reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If MemRead_i|MemWrite_i: latch addr_i and wdata_i, latch we=MemWrite_i, go to BUSY.
  - If both strobes are high, write wins (we=1).
  - mem_ack_i is ignored in IDLE.
- BUSY:
  - mem_req_o=1 with stable addr/we/wdata.
  - Counter increments each cycle, starting from 0.
  - On mem_ack_i: for a read, rdata_o<=mem_rdata_i (writes leave rdata_o unchanged); go to DONE.
  - On counter==TIMEOUT-1 with no ack: rdata_o<=0, set the abort flag, go to DONE.
  - An ack arriving in the timeout cycle wins: normal completion, no error.
- DONE:
  - mem_req_o=0; err_o=abort flag; counter cleared.
  - Go to IDLE unconditionally. The MEM-stage strobes are not sampled in DONE, because the pipeline advances at the end of this cycle.
- stall_o is combinational: (IDLE && (MemRead_i|MemWrite_i)) || BUSY. It is 0 in DONE.
- Minimum latency: ack in the first BUSY cycle gives 2 stall cycles; the pipeline advances in cycle 3.
- Back-to-back memory instructions: IDLE re-detects the next strobe the cycle after DONE, with no extra bubble.
- rdata_o holds its last captured value until the next read completion, abort or reset.
- mem_addr_o/mem_wdata_o hold their last latched values outside BUSY.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps.

Test Plan:
- Reset check: assert rst_i=0 mid-BUSY, asynchronously between edges -> mem_req_o, stall_o, err_o drop to 0 immediately; state IDLE; a later ack is ignored.
- Load with 0-wait ack:
  - Stimulus: MemRead_i=1, addr_i=0x10; ack with rdata=0xDEADBEEF in the first BUSY cycle.
  - Response: stall_o=1 for exactly 2 cycles; mem_addr_o=0x10, mem_we_o=0; rdata_o=0xDEADBEEF in DONE; err_o=0.
- Store with 5-cycle ack:
  - Stimulus: MemWrite_i=1, addr_i=0x20, wdata_i=0x5; ack after 5 cycles.
  - Response: mem_we_o=1, mem_wdata_o=0x5 stable for 5 cycles; stall_o=1 for 6 cycles; rdata_o unchanged.
- Timeout (TIMEOUT=4): read, never ack -> mem_req_o=1 for exactly 4 cycles; err_o=1 for one cycle in DONE; rdata_o=0. Ack at counter==3 -> normal completion, err_o=0.
- Back-to-back: lw then sw in consecutive MEM slots, each acked immediately -> stall pattern 1,1,0,1,1,0; second request latches the second address.
- Both strobes high with addr_i=0x30 -> mem_we_o=1. Spurious mem_ack_i in IDLE -> no state change, rdata_o unchanged.
